// File: rtl/hilo_pkg.sv
// Shared definitions for the execute-stage HI/LO multiply/divide unit.
//   hilo_state_t : control FSM states of hilo_md_unit
//   DIV_ITERS    : quotient bits produced by the iterative divider
//   DIV0_QUOT    : LO value written on a divide by zero
//   magnitude()  : absolute value of an operand when treated as signed
package hilo_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    FIX,
    DONE
  } hilo_state_t;

  localparam int unsigned DIV_ITERS = 32;
  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

  // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/hilo_md_unit_div_iter.sv
// Radix-2 restoring divider on unsigned magnitudes, one quotient bit per clock.
//   clk, rst  : clock, asynchronous active-high reset
//   start     : load dividend/divisor and begin a DIV_ITERS-cycle division
//   dividend  : unsigned dividend magnitude
//   divisor   : unsigned divisor magnitude
//   quot, rem : result, valid from the edge that completes the last iteration
//   last      : high during the cycle whose edge performs the final iteration
module div_iter
  import hilo_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quot,
  output logic [31:0] rem,
  output logic        last
);

  // acc = {partial remainder, remaining dividend bits / quotient bits}
  logic [63:0] acc;
  logic [5:0]  cnt;
  logic [32:0] trial;

  // The shifted partial remainder can need 33 bits before the subtract.
  assign trial = acc[63:31] - {1'b0, divisor};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= 6'(DIV_ITERS);
    end else if (start) begin
      acc <= {32'd0, dividend};
      cnt <= '0;
    end else if (cnt != 6'(DIV_ITERS)) begin
      if (!trial[32]) begin
        acc <= {trial[31:0], acc[30:0], 1'b1};
      end else begin
        acc <= {acc[62:0], 1'b0};
      end
      cnt <= cnt + 6'd1;
    end
  end

  assign quot = acc[31:0];
  assign rem  = acc[63:32];
  assign last = (cnt == 6'(DIV_ITERS - 1));

endmodule

// File: rtl/hilo_md_unit.sv
// Execute-stage HI/LO unit: MTHI/MTLO, MULT/MULTU, DIV/DIVU.
//   clk, rst       : clock, asynchronous active-high reset
//   flush          : cancels the instruction in EX (aborts a running op)
//   hilowrite      : EX instruction writes HI/LO
//   regToHilo_hi   : MTHI, srca -> HI
//   regToHilo_lo   : MTLO, srca -> LO
//   mdToHilo       : multiply/divide result -> HI/LO
//   mulOrdiv       : 1 = multiply, 0 = divide
//   isSign         : signed operands
//   srca, srcb     : rs / rt operands
//   stall_e        : freezes IF/ID/EX while a mul/div is in progress
//   hi_o, lo_o     : architectural HI/LO registers
// Only WIDTH = 32 is supported.
module hilo_md_unit
  import hilo_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             hilowrite,
  input  logic             regToHilo_hi,
  input  logic             regToHilo_lo,
  input  logic             mdToHilo,
  input  logic             mulOrdiv,
  input  logic             isSign,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             stall_e,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  hilo_state_t state, next_state;

  logic             idle_wr;
  logic             start;
  logic [WIDTH-1:0] a_q, b_q;
  logic             sign_q;
  logic             sa, sb;

  logic [2*WIDTH-1:0] a_ext, b_ext, product;

  logic [WIDTH-1:0] div_quot, div_rem;
  logic [WIDTH-1:0] quot_fix, rem_fix;
  logic             div_last;

  // Gating with rst keeps stall_e low for the whole reset, even while the
  // held mul/div instruction is still presented on the inputs.
  assign idle_wr = (state == IDLE) && hilowrite && !flush && !rst;
  assign start   = idle_wr && mdToHilo;

  assign stall_e = start || (state == MUL) || (state == DIV) || (state == FIX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // mul vs div is captured by the MUL/DIV state itself, so mulOrdiv needs
  // no separate latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = mulOrdiv ? MUL : DIV;
      MUL:  next_state = flush ? IDLE : DONE;
      DIV: begin
        if (flush)         next_state = IDLE;
        else if (div_last) next_state = FIX;
      end
      FIX:  next_state = flush ? IDLE : DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      sign_q <= 1'b0;
    end else if (start) begin
      a_q    <= srca;
      b_q    <= srcb;
      sign_q <= isSign;
    end
  end

  assign sa = sign_q && a_q[WIDTH-1];
  assign sb = sign_q && b_q[WIDTH-1];

  // Sign- or zero-extend to the full product width; the low 2*WIDTH bits of
  // the product are then correct for both signed and unsigned operands.
  assign a_ext   = {{WIDTH{sa}}, a_q};
  assign b_ext   = {{WIDTH{sb}}, b_q};
  assign product = a_ext * b_ext;

  div_iter u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (start && !mulOrdiv),
    .dividend (magnitude(srca, isSign)),
    .divisor  (magnitude(srcb, isSign)),
    .quot     (div_quot),
    .rem      (div_rem),
    .last     (div_last)
  );

  assign quot_fix = (sa ^ sb) ? (~div_quot + 32'd1) : div_quot;
  assign rem_fix  = sa        ? (~div_rem + 32'd1)  : div_rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_o <= '0;
      lo_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (idle_wr && regToHilo_hi) hi_o <= srca;
          if (idle_wr && regToHilo_lo) lo_o <= srca;
        end
        MUL: begin
          if (!flush) {hi_o, lo_o} <= product;
        end
        FIX: begin
          if (!flush) begin
            if (b_q == '0) begin
              hi_o <= a_q;
              lo_o <= DIV0_QUOT;
            end else begin
              hi_o <= rem_fix;
              lo_o <= quot_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/hilo_md_unit.md
# hilo_md_unit

Execute-stage HI/LO unit that consumes the main decoder's HI/LO control bundle (`hilowrite`, `regToHilo_hi/lo`, `mdToHilo`, `mulOrdiv`, `isSign`) and carries out the requested operation.
- MTHI/MTLO complete in a single cycle.
- MULT/MULTU and DIV/DIVU run as multi-cycle operations that stall the pipeline through `stall_e`.
- The block owns the architectural HI/LO registers and drives them directly to the MFHI/MFLO mux.

## Interface
- `WIDTH`, 32, operand and HI/LO width; only 32 is supported.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  pipeline flush; cancels the operation in EX.
- `hilowrite`  in  1  the instruction in EX writes HI/LO.
- `regToHilo_hi`  in  1  MTHI: `srca` → HI.
- `regToHilo_lo`  in  1  MTLO: `srca` → LO.
- `mdToHilo`  in  1  mul/div result → HI/LO.
- `mulOrdiv`  in  1  1 = multiply, 0 = divide.
- `isSign`  in  1  1 = signed operands.
- `srca`  in  32  rs value (dividend, multiplicand, MT source).
- `srcb`  in  32  rt value (divisor, multiplier).
- `stall_e`  out  1  freeze IF/ID/EX; 0 at reset.
- `hi_o`  out  32  HI register; 0 at reset.
- `lo_o`  out  32  LO register; 0 at reset.

## Operation
- **FSM states:** IDLE, MUL, DIV, FIX, DONE. Reset value is IDLE.
- **start** = IDLE & hilowrite & mdToHilo & ~flush.
  - On start, latch `srca`, `srcb`, `isSign` and `mulOrdiv`.
  - Next state is MUL if `mulOrdiv`, else DIV.
- **MT path:** IDLE & hilowrite & regToHilo_hi & ~flush writes HI ← `srca` at the edge. The same applies to LO. No stall.
- **MUL:** the registered operands feed a 64-bit product, signed or unsigned per `isSign`. The edge writes {HI, LO} ← product. Next state is DONE.
- **DIV:** radix-2 restoring division on the magnitudes, one quotient bit per cycle, 32 cycles, in sub-module `div_iter`. After the 32nd iteration, next state is FIX.
- **FIX** (signed only applies):
  - Quotient is negated if sa^sb.
  - Remainder is negated if sa.
  - The edge writes LO ← quotient, HI ← remainder. Next state is DONE.
- **Divide by zero:** HI ← dividend as latched, LO ← 32'hFFFFFFFF. Signed and unsigned give the same result.
- **Overflow:** signed 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
- **DONE:** `stall_e` = 0 so the instruction retires from EX at this edge. DONE → IDLE unconditionally. No start is accepted in DONE, which prevents re-triggering on the held instruction.
- **stall_e** = start | (state ∈ {MUL, DIV, FIX}). It is combinational from the state and the inputs.
- **flush:**
  - In MUL, DIV or FIX: abort, go to IDLE next edge, no HI/LO write.
  - In IDLE: suppresses start and MT writes.
- **rst mid-operation:** returns the FSM to IDLE, clears HI/LO to 0 and drops `stall_e` immediately.

## Timing
- Start detected in cycle T.
- **Multiply:**
  - `stall_e` = 1 in T and T+1.
  - HI/LO are updated at the end of T+1.
  - DONE is at T+2, with `stall_e` = 0.
  - 2 stall cycles.
- **Divide:**
  - `stall_e` = 1 in T through T+33: T, 32 DIV cycles, FIX.
  - HI/LO are updated at the end of T+33.
  - DONE is at T+34.
  - 34 stall cycles.
- **MTHI/MTLO:** HI/LO are visible on `hi_o`/`lo_o` in the cycle after the write edge. Forwarding to a younger MFHI is not this block's job.
- **Inputs** are sampled only in IDLE; the latched operands hold through the operation.

## Structure
- **Shared package** `hilo_pkg`:
  - state enum (IDLE, MUL, DIV, FIX, DONE);
  - constant `DIV_ITERS` = 32;
  - constant `DIV0_QUOT` = 32'hFFFFFFFF.
- **Sub-module** `div_iter`:
  - holds a 64-bit partial-remainder/quotient shift register and a 6-bit iteration counter;
  - interface: `start`, `dividend`, `divisor` (magnitudes) in; `quot`, `rem`, `last` out;
  - has the same `clk`/`rst`.
- **Top** `hilo_md_unit`: FSM, operand and sign latches, product register, sign fix-up, HI/LO registers.

## Test plan
- **MULT** 0xFFFFFFFE × 0x00000003 → HI = 0xFFFFFFFF, LO = 0xFFFFFFFA, `stall_e` high for exactly 2 cycles. **MULTU**, same operands → HI = 0x00000002, LO = 0xFFFFFFFA.
- **DIV** 0xFFFFFFF9 (−7) / 0x00000002 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF, `stall_e` high for exactly 34 cycles. **DIV** 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- **DIVU** 0x00000007 / 0 → HI = 0x00000007, LO = 0xFFFFFFFF.
- **Flush and reset during DIV:**
  - Preload HI = 0x11, LO = 0x22, start DIV, assert `flush` at DIV cycle 10 → `stall_e` = 0 next cycle, HI/LO still 0x11/0x22, FSM in IDLE.
  - Repeat with `rst` at the same point → HI = LO = 0 and `stall_e` = 0 immediately.
- **Back-to-back MT:** MTHI 0x1234 then MTLO 0xABCD on consecutive cycles → `hi_o` = 0x1234 and `lo_o` = 0xABCD, `stall_e` never asserted.
- **Consecutive MULT, MULT:** the second starts the cycle after DONE → no double execution, final HI/LO equal the second product.
